// File: rtl/sseg_pkg.sv
// Shared constants and the hex-to-segment decoder for the seven-segment scan controller.
package sseg_pkg;

  // Everything dark: all cathodes high, decimal point off.
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  // Only the decimal point lit. Used for a suppressed leading zero that carries a dp.
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

  // Active-low g..a patterns for 0-F, where bit 0 is segment a.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction

endpackage

// File: rtl/sseg_lz_mask.sv
// Leading-zero mask. Bit i is set when digits i..N_DIGITS-1 are all zero.
// Digit 0 is never masked, so a value of zero still shows a single "0".
module sseg_lz_mask #(
  parameter int N_DIGITS = 4
) (
  input  logic [4*N_DIGITS-1:0] hex,
  output logic [N_DIGITS-1:0]   mask
);

  logic all_zero;

  // Walk from the most significant digit downwards while the digits stay zero.
  always_comb begin
    mask     = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (hex[4*i +: 4] == 4'h0);
      mask[i]  = all_zero;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller. Provides per-digit dp,
// blank and blink, leading-zero suppression, PWM brightness and registered outputs.
module sseg_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_CYCLES = 62500,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_SCANS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic                  scan_tick
);

  import sseg_pkg::*;

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int BLK_W  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_SCANS - 1);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_off;

  logic                slot_end;
  logic                scan_wrap;
  logic [N_DIGITS-1:0] lz_mask;
  logic [3:0]          cur_hex;
  logic                duty_on;
  logic                dark;
  logic                suppressed;
  logic [N_DIGITS-1:0] an_p0;
  logic [7:0]          seg_p0;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign scan_wrap = slot_end && (dig_idx == IDX_LAST);

  sseg_lz_mask #(.N_DIGITS(N_DIGITS)) u_lz_mask (
    .hex  (hex),
    .mask (lz_mask)
  );

  // Scan timing: slot counter, digit index, free-running PWM counter and blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      dig_idx   <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_end) begin
        slot_cnt <= '0;
        // Explicit compare so non-power-of-2 digit counts wrap correctly.
        if (dig_idx == IDX_LAST) dig_idx <= '0;
        else                     dig_idx <= dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (scan_wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Next anode/cathode pattern for the digit selected by the current counter state.
  always_comb begin
    cur_hex    = hex[{dig_idx, 2'b00} +: 4];
    duty_on    = (pwm_cnt < bright) || (bright == '1);
    // slot_cnt == 0 is the guard cycle, which keeps the anodes off while the digit changes.
    dark       = (slot_cnt == '0) || blank[dig_idx] ||
                 (blink[dig_idx] && blink_off) || !duty_on;
    suppressed = lz_en && lz_mask[dig_idx];
    an_p0      = '1;
    seg_p0     = SEG_BLANK;
    if (!dark) begin
      if (suppressed) begin
        if (dp[dig_idx]) begin
          an_p0[dig_idx] = 1'b0;
          seg_p0         = SEG_DP_ONLY;
        end
      end else begin
        an_p0[dig_idx] = 1'b0;
        seg_p0         = {~dp[dig_idx], hex_to_seg(cur_hex)};
      end
    end
  end

  // Output register: an and seg update on the same edge, so no ghosting between digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an        <= '1;
      seg       <= SEG_BLANK;
      scan_tick <= 1'b0;
    end else begin
      an        <= an_p0;
      seg       <= seg_p0;
      scan_tick <= scan_wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl. It drives a 4-digit and a 3-digit instance,
// both with 4-cycle slots and a 2-scan blink half-period.
module tb_sseg_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] hex4;
  logic [3:0]  dp4, blank4, blink4, bright4, an4;
  logic        lz4, tick4;
  logic [7:0]  seg4;

  logic [11:0] hex3;
  logic [2:0]  dp3, blank3, blink3, an3;
  logic [3:0]  bright3;
  logic        lz3, tick3;
  logic [7:0]  seg3;

  sseg_scan_ctrl #(.N_DIGITS(4), .SLOT_CYCLES(4), .BRIGHT_W(4), .BLINK_SCANS(2)) dut4 (
    .clk(clk), .reset(reset), .hex(hex4), .dp(dp4), .blank(blank4), .blink(blink4),
    .lz_en(lz4), .bright(bright4), .an(an4), .seg(seg4), .scan_tick(tick4));

  sseg_scan_ctrl #(.N_DIGITS(3), .SLOT_CYCLES(4), .BRIGHT_W(4), .BLINK_SCANS(2)) dut3 (
    .clk(clk), .reset(reset), .hex(hex3), .dp(dp3), .blank(blank3), .blink(blink3),
    .lz_en(lz3), .bright(bright3), .an(an3), .seg(seg3), .scan_tick(tick3));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][7:0] seg;   // expected per digit, {d3,d2,d1,d0}; FF means dark
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_tick4();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick4) return;
    end
    check("tick4_timeout", 0, 1);
  endtask

  task automatic wait_tick3();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick3) return;
    end
    check("tick3_timeout", 0, 1);
  endtask

  // Observe one full scan of dut4 from its scan_tick. Check the guard cycle and one lit cycle per digit.
  task automatic scan_check4(input string tag, input logic [3:0][7:0] exp);
    logic [3:0] ea;
    int k;
    wait_tick4();
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      k = (j - 1) / 4;
      if ((j - 1) % 4 == 0) begin
        check($sformatf("%s_d%0d_guard", tag, k), {an4, seg4}, {4'hF, 8'hFF});
      end else if ((j - 1) % 4 == 2) begin
        ea = 4'hF;
        if (exp[k] != 8'hFF) ea[k] = 1'b0;
        check($sformatf("%s_d%0d", tag, k), {an4, seg4}, {ea, exp[k]});
      end
    end
  endtask

  initial begin
    logic [2:0][7:0] exp3;
    logic [2:0]      ea3;
    int cnt;
    int k;

    hex4 = 16'h1234; dp4 = '0; blank4 = '0; blink4 = '0; lz4 = 1'b0; bright4 = 4'hF;
    hex3 = 12'h5A0;  dp3 = '0; blank3 = '0; blink3 = '0; lz3 = 1'b0; bright3 = 4'hF;

    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h89EF, 4'b0101, 4'b0000, 1'b0, {8'h80, 8'h10, 8'h86, 8'h0E}};
    vecs[2] = '{16'h0070, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4] = '{16'h0000, 4'b1000, 4'b0000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hC0}};
    vecs[5] = '{16'hABCD, 4'b0100, 4'b0100, 1'b0, {8'h88, 8'hFF, 8'hC6, 8'hA1}};
    vecs[6] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[7] = '{16'h0300, 4'b0001, 4'b0000, 1'b1, {8'hFF, 8'hB0, 8'hC0, 8'h40}};
    vecs[8] = '{16'hF000, 4'b0000, 4'b0000, 1'b1, {8'h8E, 8'hC0, 8'hC0, 8'hC0}};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_an4", an4, 4'hF);
    check("rst_seg4", seg4, 8'hFF);
    check("rst_tick4", tick4, 0);
    check("rst_an3", an3, 3'h7);
    check("rst_seg3", seg3, 8'hFF);
    reset = 1'b0;

    // 3-digit scan, hex 5A0
    exp3 = {8'h92, 8'h88, 8'hC0};
    wait_tick3();
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      k = (j - 1) / 4;
      if ((j - 1) % 4 == 0) begin
        check($sformatf("n3_d%0d_guard", k), {an3, seg3}, {3'h7, 8'hFF});
      end else begin
        ea3 = 3'h7;
        ea3[k] = 1'b0;
        check($sformatf("n3_d%0d_c%0d", k, (j - 1) % 4), {an3, seg3}, {ea3, exp3[k]});
      end
    end
    wait_tick3();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (tick3) break;
    end
    check("n3_tick_period", cnt, 12);

    // Table-driven static patterns on the 4-digit instance
    for (int v = 0; v < 9; v++) begin
      hex4 = vecs[v].hex; dp4 = vecs[v].dp; blank4 = vecs[v].blank; lz4 = vecs[v].lz;
      scan_check4($sformatf("vec%0d", v), vecs[v].seg);
    end

    // A mid-slot brightness change takes effect on the next edge
    hex4 = 16'h1234; dp4 = '0; blank4 = '0; lz4 = 1'b0; bright4 = 4'hF;
    scan_check4("pre_mid", {8'hF9, 8'hA4, 8'hB0, 8'h99});
    wait_tick4();
    @(negedge clk);
    @(negedge clk);
    check("mid_lit", {an4, seg4}, {4'hE, 8'h99});
    bright4 = 4'h0;
    @(negedge clk);
    check("mid_dark", {an4, seg4}, {4'hF, 8'hFF});
    bright4 = 4'hF;
    @(negedge clk);
    check("mid_relit", {an4, seg4}, {4'hE, 8'h99});

    // PWM: lit cycles in 64. The guard cycle aligns with pwm_cnt values 0, 4, 8 and 12.
    begin
      logic [3:0] br [4];
      int exp_lit [4];
      br = '{4'd4, 4'd6, 4'd0, 4'hF};
      exp_lit = '{12, 16, 0, 48};
      for (int b = 0; b < 4; b++) begin
        bright4 = br[b];
        @(negedge clk);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
          @(negedge clk);
          if (an4 != 4'hF) cnt++;
        end
        check($sformatf("pwm_b%0d", br[b]), cnt, exp_lit[b]);
      end
    end
    bright4 = 4'hF;

    // Reset mid-slot while digit 2 is lit
    wait_tick4();
    for (int j = 0; j < 10; j++) @(negedge clk);
    check("pre_rst_d2", {an4, seg4}, {4'b1011, 8'hA4});
    reset = 1'b1;
    #1;
    check("rst_async_dark", {an4, seg4}, {4'hF, 8'hFF});
    check("rst_async_tick", tick4, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_guard", {an4, seg4}, {4'hF, 8'hFF});
    @(negedge clk);
    check("post_rst_d0", {an4, seg4}, {4'hE, 8'h99});
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (tick4) break;
    end
    check("post_rst_first_tick", cnt, 14);

    // Blink on digit 1 with a 2-scan half-period, starting from reset
    @(negedge clk);
    reset = 1'b1;
    blink4 = 4'b0010;
    @(negedge clk);
    reset = 1'b0;
    scan_check4("blink_s2", {8'hF9, 8'hA4, 8'hB0, 8'h99});
    scan_check4("blink_s3", {8'hF9, 8'hA4, 8'hFF, 8'h99});
    scan_check4("blink_s4", {8'hF9, 8'hA4, 8'hFF, 8'h99});
    scan_check4("blink_s5", {8'hF9, 8'hA4, 8'hB0, 8'h99});
    scan_check4("blink_s6", {8'hF9, 8'hA4, 8'hB0, 8'h99});
    scan_check4("blink_s7", {8'hF9, 8'hA4, 8'hFF, 8'h99});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment scan controller. Successor to the team's fixed 4-digit display mux, adding:
- arbitrary digit count, including non-power-of-2
- per-digit decimal point, blanking and blink
- leading-zero suppression
- PWM brightness
- registered, glitch-free outputs

Sits between datapath display registers and board anode/cathode pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..16)
SLOT_CYCLES, 62500, clk cycles each digit is selected (>=2)
BRIGHT_W, 4, brightness control width
BLINK_SCANS, 64, full scans per blink half-period (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset
hex  in  4*N_DIGITS  digit values; digit i = hex[4i+3:4i]; digit 0 = rightmost
dp  in  N_DIGITS  decimal point on, per digit, active-high
blank  in  N_DIGITS  force digit dark, active-high
blink  in  N_DIGITS  digit dark during blink-off phase, active-high
lz_en  in  1  leading-zero suppression enable
bright  in  BRIGHT_W  duty level; 0 = off, all-ones = 100%
an  out  N_DIGITS  anode select, active-low, one-hot-low or all-ones
seg  out  8  seg[7] = dp, seg[6:0] = g..a, all active-low
scan_tick  out  1  one-cycle pulse when digit index wraps N_DIGITS-1 -> 0

Behaviour:
- Reset (async, active-high) values:
  - an = all ones, seg = 8'hFF, scan_tick = 0
  - slot counter = 0, digit index = 0, pwm counter = 0, blink scan counter = 0, blink phase = on
- Slot counter:
  - counts 0..SLOT_CYCLES-1
  - at SLOT_CYCLES-1 wraps to 0 and advances digit index
- Digit index:
  - counts 0..N_DIGITS-1, wraps to 0 (explicit compare, not modulo width)
  - scan_tick pulses on the cycle the index wraps to 0
- Blink:
  - on each index wrap, blink scan counter increments
  - at BLINK_SCANS-1 it clears and blink phase toggles
  - first off phase starts after BLINK_SCANS full scans from reset
- PWM:
  - BRIGHT_W-bit free-running counter, increments every clk
  - duty_on = (pwm_cnt < bright) OR (bright == all-ones)
- Leading-zero suppression, when lz_en = 1:
  - digit i (i > 0) is suppressed if digits i..N_DIGITS-1 are all 4'h0
  - digit 0 is never suppressed
  - a suppressed digit still shows its dp if dp[i] = 1 (seg = 8'h7F, anode active)
- Visibility of the selected digit k:
  - dark when blank[k] = 1, OR (blink[k] = 1 and blink phase = off), OR duty_on = 0
  - dark means an = all ones and seg = 8'hFF
  - otherwise an[k] = 0 (all other bits 1), seg[6:0] = decode(hex[k]), seg[7] = ~dp[k]
- Decode table, 0-F, a = bit0:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
  - values shown with dp off
- Output timing:
  - an and seg are registered; 1-cycle latency from counter state and inputs
  - inputs sampled every cycle; a change takes effect on the following clk edge, mid-slot allowed
  - an and seg change on the same edge, so no cross-digit ghosting
- Anode guard: on each digit change, an is driven all ones for the first cycle of the new slot.
- Reset mid-scan: outputs go dark immediately (async); scan restarts at digit 0 after release.

Decomposition:
- Package sseg_pkg:
  - SEG_BLANK = 8'hFF constant
  - 16-entry seg lookup constant
  - function hex_to_seg(logic [3:0]) returning logic [6:0]
- Sub-module sseg_lz_mask: combinational, hex bus -> N_DIGITS suppression mask, parametrised by N_DIGITS.
- Counters and output registers stay in the top module.

Test Plan:
1. N_DIGITS=3, SLOT_CYCLES=4, bright=all-ones, hex=12'h5A0:
   - an sequence 110,101,011 repeats every 12 cycles
   - seg values C0, 88, 92
   - anode guard cycle all ones at each slot start
   - scan_tick every 12 cycles
2. lz_en=1, N_DIGITS=4, hex=16'h0070:
   - digits 3 and 2 dark, digit 1 = F8, digit 0 = C0
   - with hex=16'h0000, only digit 0 shows C0
   - with dp[3]=1 and hex=16'h0000, digit 3 shows 7F
3. bright=4'd4, BRIGHT_W=4: during a selected slot, anode active exactly 4 of every 16 cycles; bright=0 -> an all ones always.
4. BLINK_SCANS=2, blink=4'b0010:
   - digit 1 dark for scans 3-4, visible for scans 5-6
   - other digits unaffected
5. blank[2]=1 with dp[2]=1: digit 2 fully dark (an all ones, seg FF).
6. Assert reset mid-slot at digit 2:
   - an=all ones and seg=FF immediately
   - after release, first lit digit is 0, one cycle after the guard cycle
